// File: rtl/seq_det_pkg.sv
// Shared types and defaults for the parametrised serial pattern detector.
// Holds the fill-state enum, reset defaults and the masked compare helper.
package seq_det_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        ARMED = 2'd2
    } fill_state_e;

    localparam logic [31:0] PAT_RST_DEF = 32'd5;
    localparam logic        OVL_RST_DEF = 1'b1;

    // Operands are zero-extended to 32 bits by the caller, so the unused
    // upper bits always compare equal.
    function automatic logic masked_eq(
        input logic [31:0] hist,
        input logic [31:0] pat,
        input logic [31:0] mask
    );
        return ((hist ^ pat) & ~mask) == 32'd0;
    endfunction

endpackage

// File: rtl/seq_det_shift.sv
// History shift register (newest bit at LSB) with saturating fill count.
// Ports: clk, reset, shift_en, a, clr (history+fill), fill_clr, next_hist, full.
module seq_det_shift #(
    parameter int PAT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             shift_en,
    input  logic             a,
    input  logic             clr,
    input  logic             fill_clr,
    output logic [PAT_W-1:0] next_hist,
    output logic             full
);

    localparam int FW = $clog2(PAT_W + 1);

    logic [PAT_W-1:0] hist_q, hist_d;
    logic [FW-1:0]    fill_q, fill_d;

    assign next_hist = {hist_q[PAT_W-2:0], a};

    // Fill count as it will be after this cycle's shift reaches PAT_W.
    assign full = (fill_q >= FW'(PAT_W - 1));

    always_comb begin
        hist_d = hist_q;
        fill_d = fill_q;
        if (clr) begin
            hist_d = '0;
            fill_d = '0;
        end else begin
            if (shift_en) begin
                hist_d = next_hist;
                if (fill_q != FW'(PAT_W)) begin
                    fill_d = fill_q + FW'(1);
                end
            end
            // Non-overlap match: history kept, but PAT_W fresh bits needed.
            if (fill_clr) begin
                fill_d = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist_q <= '0;
            fill_q <= '0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
        end
    end

endmodule

// File: rtl/seq_detector_param.sv
// Parametrised serial pattern detector with runtime-reloadable pattern.
// Ports: clk, reset, a/a_vld stream, cfg_we/cfg_pattern/cfg_overlap
// (+cfg_mask when SEQDET_MASK_EN is defined), cnt_clr; outputs w,
// match_cnt (saturating) and armed.
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int               PAT_W   = 3,
    parameter logic [PAT_W-1:0] PAT_RST = PAT_W'(PAT_RST_DEF),
    parameter logic             OVL_RST = OVL_RST_DEF,
    parameter int               CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             a,
    input  logic             a_vld,
    input  logic             cfg_we,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic             cfg_overlap,
`ifdef SEQDET_MASK_EN
    input  logic [PAT_W-1:0] cfg_mask,
`endif
    input  logic             cnt_clr,
    output logic             w,
    output logic [CNT_W-1:0] match_cnt,
    output logic             armed
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    fill_state_e      state_q, state_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic             ovl_q, ovl_d;
    logic             w_q, w_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PAT_W-1:0] mask_w;
    logic [PAT_W-1:0] next_hist;
    logic             full;
    logic             accept;
    logic             hit;
    logic             nov_hit;

`ifdef SEQDET_MASK_EN
    logic [PAT_W-1:0] mask_q, mask_d;

    always_comb begin
        mask_d = mask_q;
        if (cfg_we) begin
            mask_d = cfg_mask;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mask_q <= '0;
        end else begin
            mask_q <= mask_d;
        end
    end

    assign mask_w = mask_q;
`else
    assign mask_w = '0;
`endif

    // A reload in the same cycle drops the incoming bit.
    assign accept  = a_vld & ~cfg_we;
    assign hit     = accept & full &
                     masked_eq(32'(next_hist), 32'(pat_q), 32'(mask_w));
    assign nov_hit = hit & ~ovl_q;

    seq_det_shift #(
        .PAT_W (PAT_W)
    ) u_shift (
        .clk       (clk),
        .reset     (reset),
        .shift_en  (accept),
        .a         (a),
        .clr       (cfg_we),
        .fill_clr  (nov_hit),
        .next_hist (next_hist),
        .full      (full)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (cfg_we) begin
            state_d = IDLE;
        end else if (accept) begin
            unique case (state_q)
                IDLE:    state_d = FILL;
                FILL:    if (full) state_d = nov_hit ? IDLE : ARMED;
                ARMED:   if (nov_hit) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        armed = (state_q == ARMED);
    end

    always_comb begin
        pat_d = pat_q;
        ovl_d = ovl_q;
        if (cfg_we) begin
            pat_d = cfg_pattern;
            ovl_d = cfg_overlap;
        end
        w_d   = hit;
        // Clear and match together leave a count of one.
        cnt_d = cnt_clr ? '0 : cnt_q;
        if (hit && cnt_d != CNT_MAX) begin
            cnt_d = cnt_d + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pat_q <= PAT_RST;
            ovl_q <= OVL_RST;
            w_q   <= 1'b0;
            cnt_q <= '0;
        end else begin
            pat_q <= pat_d;
            ovl_q <= ovl_d;
            w_q   <= w_d;
            cnt_q <= cnt_d;
        end
    end

    assign w         = w_q;
    assign match_cnt = cnt_q;

endmodule
